// File: rtl/machine_seq_pkg.sv
// Shared types and constants for the nibble sequencer: FSM states, widths
// and the beat-selector to shift-amount table.
package machine_seq_pkg;

    localparam int NIB_W  = 4;
    localparam int WORD_W = 16;
    localparam int BEATS  = 4;
    localparam int CNT_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit offset of each nibble inside the held word, indexed by ds.
    localparam logic [3:0] SHIFT_TABLE [BEATS] = '{4'd0, 4'd4, 4'd8, 4'd12};

endpackage

// File: rtl/machine_nib_shift.sv
// Beat-selector decode: picks nibble ds of the held word through the
// package shift table.
module machine_nib_shift
    import machine_seq_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [CNT_W-1:0]  ds,
    output logic [NIB_W-1:0]  nib
);

    logic [WORD_W-1:0] shifted;

    assign shifted = word >> SHIFT_TABLE[ds];
    assign nib     = shifted[NIB_W-1:0];

endmodule

// File: rtl/machine_nibble_sequencer.sv
// Serializes 16-bit words into four 4-bit beats with valid/ready on both sides.
// Define MACHINE_NIBSEQ_MSB_FIRST_EN to emit the most significant nibble first.
module machine_nibble_sequencer
    import machine_seq_pkg::*;
(
    input  logic              system1000,
    input  logic              system1000_rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NIB_W-1:0]  out_nib,
    output logic              out_first,
    output logic              out_last,
    output logic [CNT_W-1:0]  ds,
    output logic              busy
);

    // Handshake rule: a transfer happens on a rising edge where valid and
    // ready are both high; valid never depends on ready, ready may depend on
    // valid/ready of the other side (in_ready follows out_ready on the last beat).

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [NIB_W-1:0]  shift_nib;
    logic              last_beat;

    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_d  = in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                // Zero-bubble reload: the next word is taken on the final-beat handshake.
                in_ready  = last_beat && out_ready;
                if (out_ready) begin
                    if (!last_beat) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (in_valid) begin
                        word_d = in_data;
                        cnt_d  = '0;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ds = '0;
        if (state_q == SHIFT) begin
`ifdef MACHINE_NIBSEQ_MSB_FIRST_EN
            ds = CNT_W'(BEATS - 1) - cnt_q;
`else
            ds = cnt_q;
`endif
        end
    end

    machine_nib_shift u_shift (
        .word (word_q),
        .ds   (ds),
        .nib  (shift_nib)
    );

    assign out_nib   = out_valid ? shift_nib : '0;
    assign out_first = out_valid && (cnt_q == '0);
    assign out_last  = out_valid && last_beat;

endmodule
